cv32e40x_div: RTL and testbench
===============================

CV32E40X_DIV -- requirements
Module: cv32e40x_div

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL provide these ports, as name / direction / width / meaning:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- valid_i  in  1  operation request.
- ready_o  out  1  block can accept a request; high only in IDLE.
- kill_i  in  1  abort the current operation.
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- op_a_i  in  32  dividend.
- op_b_i  in  32  divisor.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  32  quotient or remainder.
- div_clz_en_o  out  1  requests the ALU CLZ.
- div_clz_data_o  out  32  CLZ input.
- div_clz_result_i  in  6  leading-zero count, 32 when the input is zero.
- div_shift_en_o  out  1  requests the ALU left shift.
- div_shift_amt_o  out  6  shift amount; bit 5 is always 0.
- div_alu_op_a_o  out  32  shift source; muxed onto ALU operand A by the integration while div_shift_en_o is high.
- div_op_a_shifted_i  in  32  shift result from the ALU.

Function
REQ-004 The block SHALL implement the states IDLE, CLZ, SHIFT, DIVIDE and FINISH.
REQ-005 In IDLE the block SHALL assert ready_o; when valid_i=1 and kill_i=0, it SHALL register op_i, |op_a_i| and |op_b_i|, plus both sign bits (signed ops only), and go to CLZ.
REQ-006 In CLZ the block SHALL assert div_clz_en_o with div_clz_data_o=|b| and register cnt=div_clz_result_i.
- If the result is 32 (divide by zero), the block SHALL go to FINISH with Q=0xFFFFFFFF and R=a.
- Otherwise the block SHALL go to SHIFT.
REQ-007 In SHIFT the block SHALL assert div_shift_en_o with div_shift_amt_o={0,cnt[4:0]} and div_alu_op_a_o=|b|, register D=div_op_a_shifted_i, and set R=|a|, Q=0 before going to DIVIDE.
REQ-008 In DIVIDE the block SHALL perform one restoring step per cycle for cnt+1 cycles:
- if R>=D (unsigned), R=R-D and Q={Q[30:0],1}; otherwise Q={Q[30:0],0};
- D=D>>1 in either case;
- after the last step, go to FINISH.
REQ-009 In FINISH the block SHALL apply signs:
- quotient is negated when the operand signs differ and b is nonzero (DIV only);
- remainder is negated when a was negative (REM only).
REQ-010 In FINISH the block SHALL drive result_o and assert valid_o, holding both stable until ready_i=1, then return to IDLE.
REQ-011 Latency from the accept edge to valid_o SHALL be clz(|b|)+4 cycles, or 2 cycles for divide by zero.
REQ-012 DIV 0x80000000/0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0 without special casing; the 33-bit |a| magnitude wraps naturally.
REQ-013 kill_i=1 in any state SHALL force IDLE on the next edge with valid_o=0.
REQ-014 kill_i SHALL take priority over valid_i in IDLE and over ready_i in FINISH.
REQ-015 div_clz_en_o, div_shift_en_o and valid_o SHALL each be high only in their own state and SHALL be mutually exclusive.
REQ-016 Outside their states, div_clz_data_o, div_alu_op_a_o and div_shift_amt_o SHALL be driven to 0.

Reset
REQ-017 While rst=1, the block SHALL asynchronously set state=IDLE, Q=R=D=cnt=0, ready_o=1, valid_o=0, result_o=0 and both enables to 0.
REQ-018 Reset asserted mid-operation SHALL discard the operation and produce no valid_o after release.

Configuration
REQ-019 With CV32E40X_DIV_EARLY_EXIT_EN defined, CLZ state SHALL also compare |a|<|b| (unsigned, b nonzero) and, if true, go directly to FINISH with Q=0 and R=|a|; latency is then 2 cycles.
REQ-020 Without CV32E40X_DIV_EARLY_EXIT_EN, no comparator SHALL be built and every nonzero-divisor operation SHALL follow REQ-007 and REQ-008.

Verification
REQ-021 Scenario: DIVU 100/7 -> result 14, valid_o 33 cycles after accept; REMU 100/7 -> result 2.
REQ-022 Scenario: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
REQ-023 Scenario: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; each with valid_o at cycle 2.
REQ-024 Scenario: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-025 Scenario: DIVU 3/10 -> result 0, valid_o at cycle 2 with the macro and cycle 32 without it.
REQ-026 Scenario: kill_i pulsed in the 5th DIVIDE cycle -> IDLE and ready_o=1 next cycle, no valid_o; result held 3 cycles with ready_i=0 -> result_o stable; rst pulsed mid-DIVIDE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cv32e40x_div_if.sv
// Handshake, operand and ALU-sharing signals of the iterative divider.
// The slave modport is the divider; the master modport is the core/ALU side.
interface cv32e40x_div_if;
    logic        valid_i;
    logic        ready_o;
    logic        kill_i;
    logic [1:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        div_clz_en_o;
    logic [31:0] div_clz_data_o;
    logic [5:0]  div_clz_result_i;
    logic        div_shift_en_o;
    logic [5:0]  div_shift_amt_o;
    logic [31:0] div_alu_op_a_o;
    logic [31:0] div_op_a_shifted_i;

    modport slave (
        input  valid_i, kill_i, op_i, op_a_i, op_b_i, ready_i,
        input  div_clz_result_i, div_op_a_shifted_i,
        output ready_o, valid_o, result_o,
        output div_clz_en_o, div_clz_data_o, div_shift_en_o, div_shift_amt_o, div_alu_op_a_o
    );

    modport master (
        output valid_i, kill_i, op_i, op_a_i, op_b_i, ready_i,
        output div_clz_result_i, div_op_a_shifted_i,
        input  ready_o, valid_o, result_o,
        input  div_clz_en_o, div_clz_data_o, div_shift_en_o, div_shift_amt_o, div_alu_op_a_o
    );
endinterface

// File: rtl/cv32e40x_div.sv
// Iterative restoring divider borrowing the ALU CLZ and shifter for divisor alignment.
// Define CV32E40X_DIV_EARLY_EXIT_EN to finish immediately when |a| < |b|.
module cv32e40x_div (
    input  logic          clk,
    input  logic          rst,
    cv32e40x_div_if.slave bus
);
    // IDLE accept | CLZ count divisor zeros | SHIFT align divisor | DIVIDE one step/cycle | FINISH sign fix, hold result
    typedef enum logic [2:0] {S_IDLE, S_CLZ, S_SHIFT, S_DIVIDE, S_FINISH} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [31:0] r_d;
    logic [5:0]  r_cnt;

    logic        w_signed;
    logic        w_accept;
    logic        w_b_zero;
    logic        w_early;
    logic        w_r_ge_d;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_res;
    logic [31:0] w_r_res;

    assign w_signed = ~bus.op_i[0];
    assign w_accept = bus.valid_i & ~bus.kill_i;
    assign w_abs_a  = (w_signed && bus.op_a_i[31]) ? (32'd0 - bus.op_a_i) : bus.op_a_i;
    assign w_abs_b  = (w_signed && bus.op_b_i[31]) ? (32'd0 - bus.op_b_i) : bus.op_b_i;
    assign w_b_zero = (bus.div_clz_result_i == 6'd32);
    assign w_r_ge_d = (r_r >= r_d);

`ifdef CV32E40X_DIV_EARLY_EXIT_EN
    assign w_early = ~w_b_zero & (r_a < r_b);
`else
    assign w_early = 1'b0;
`endif

    // Sign bits are only captured for signed ops, so unsigned results pass through.
    assign w_q_res = ((r_sign_a ^ r_sign_b) && (r_b != 32'd0)) ? (32'd0 - r_q) : r_q;
    assign w_r_res = r_sign_a ? (32'd0 - r_r) : r_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        bus.ready_o         = 1'b0;
        bus.valid_o         = 1'b0;
        bus.result_o        = 32'd0;
        bus.div_clz_en_o    = 1'b0;
        bus.div_clz_data_o  = 32'd0;
        bus.div_shift_en_o  = 1'b0;
        bus.div_shift_amt_o = 6'd0;
        bus.div_alu_op_a_o  = 32'd0;
        case (r_state)
            S_IDLE: begin
                bus.ready_o = 1'b1;
                if (w_accept) w_state_nxt = S_CLZ;
            end
            S_CLZ: begin
                bus.div_clz_en_o   = 1'b1;
                bus.div_clz_data_o = r_b;
                w_state_nxt        = (w_b_zero || w_early) ? S_FINISH : S_SHIFT;
            end
            S_SHIFT: begin
                bus.div_shift_en_o  = 1'b1;
                bus.div_shift_amt_o = {1'b0, r_cnt[4:0]};
                bus.div_alu_op_a_o  = r_b;
                w_state_nxt         = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (r_cnt == 6'd0) w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                bus.valid_o  = 1'b1;
                bus.result_o = r_op[1] ? w_r_res : w_q_res;
                if (bus.ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.kill_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 2'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_q      <= 32'd0;
            r_r      <= 32'd0;
            r_d      <= 32'd0;
            r_cnt    <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= bus.op_i;
                        r_sign_a <= w_signed & bus.op_a_i[31];
                        r_sign_b <= w_signed & bus.op_b_i[31];
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                    end
                end
                S_CLZ: begin
                    r_cnt <= bus.div_clz_result_i;
                    if (w_b_zero) begin
                        r_q <= 32'hFFFF_FFFF;
                        r_r <= r_a;
                    end else if (w_early) begin
                        r_q <= 32'd0;
                        r_r <= r_a;
                    end
                end
                S_SHIFT: begin
                    r_d <= bus.div_op_a_shifted_i;
                    r_r <= r_a;
                    r_q <= 32'd0;
                end
                S_DIVIDE: begin
                    if (w_r_ge_d) r_r <= r_r - r_d;
                    r_q <= {r_q[30:0], w_r_ge_d};
                    r_d <= r_d >> 1;
                    if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40x_div.sv
// Directed and randomized checks of cv32e40x_div against an arithmetic reference model,
// with a behavioural CLZ/shifter standing in for the shared ALU.
module tb_cv32e40x_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cv32e40x_div_if bus ();

    cv32e40x_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [5:0] clz32(input logic [31:0] x);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return n;
            n++;
        end
        return n;
    endfunction

    always_comb begin
        bus.div_clz_result_i   = clz32(bus.div_clz_data_o);
        bus.div_op_a_shifted_i = bus.div_alu_op_a_o << bus.div_shift_amt_o;
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        if (mb == 0) return 2;
`ifdef CV32E40X_DIV_EARLY_EXIT_EN
        if (ma < mb) return 2;
`endif
        return int'(clz32(mb)) + 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.op_a_i  = a;
        bus.op_b_i  = b;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.op_a_i  = $urandom;
        bus.op_b_i  = $urandom;
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        int lat;
        logic [31:0] exp_res;
        exp_res = ref_result(op, a, b);
        @(negedge clk);
        check({tag, ".ready_idle"}, 32'(bus.ready_o), 32'd1);
        bus.ready_i = 1'b0;
        start_op(op, a, b);
        lat = 1;
        while (!bus.valid_o && lat < 80) begin
            check({tag, ".busy"}, {30'd0, bus.ready_o, bus.div_clz_en_o & bus.div_shift_en_o}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check({tag, ".result"}, bus.result_o, exp_res);
        check({tag, ".finish_idle_outs"},
              {bus.ready_o, bus.div_clz_en_o, bus.div_shift_en_o, bus.div_shift_amt_o} |
              bus.div_clz_data_o | bus.div_alu_op_a_o, 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check({tag, ".hold"}, {bus.result_o[31:1], bus.result_o[0] ^ ~bus.valid_o},
                  {exp_res[31:1], exp_res[0]});
        end
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        check({tag, ".release"}, {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.op_i    = 2'd0;
        bus.op_a_i  = 32'd0;
        bus.op_b_i  = 32'd0;
        bus.ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", 32'(bus.ready_o), 32'd1);
        check("reset.valid", 32'(bus.valid_o), 32'd0);
        check("reset.result", bus.result_o, 32'd0);
        check("reset.enables", {30'd0, bus.div_clz_en_o, bus.div_shift_en_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'd1, 32'd100, 32'd7, 0, "divu_100_7");
        run_op(2'd3, 32'd100, 32'd7, 0, "remu_100_7");
        run_op(2'd0, -32'sd7, 32'd2, 0, "div_m7_2");
        run_op(2'd2, -32'sd7, 32'd2, 0, "rem_m7_2");
        run_op(2'd0, 32'd7, -32'sd2, 0, "div_7_m2");
        run_op(2'd2, 32'd7, -32'sd2, 0, "rem_7_m2");
        run_op(2'd1, 32'd5, 32'd0, 0, "divu_5_0");
        run_op(2'd3, 32'd5, 32'd0, 0, "remu_5_0");
        run_op(2'd0, -32'sd5, 32'd0, 0, "div_m5_0");
        run_op(2'd2, -32'sd5, 32'd0, 0, "rem_m5_0");
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(2'd1, 32'd3, 32'd10, 3, "divu_3_10_hold");

        // Kill in the fifth DIVIDE cycle of DIVU 100/7.
        start_op(2'd1, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        bus.kill_i = 1'b0;
        check("kill.idle", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
        watch_no_valid("kill.no_valid", 40);

        // Kill beats valid in IDLE.
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.kill_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
        check("kill_idle.stay", {30'd0, bus.div_clz_en_o, bus.ready_o}, 32'd1);

        // Kill in FINISH with ready_i low.
        start_op(2'd1, 32'd5, 32'd0);
        @(posedge clk);
        #1;
        check("kill_fin.valid", 32'(bus.valid_o), 32'd1);
        @(negedge clk);
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        bus.kill_i = 1'b0;
        check("kill_fin.idle", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);

        // Reset mid-DIVIDE.
        start_op(2'd1, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid.ready_valid", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
        check("rst_mid.result", bus.result_o, 32'd0);
        check("rst_mid.enables", {30'd0, bus.div_clz_en_o, bus.div_shift_en_o}, 32'd0);
        check("rst_mid.buses", bus.div_clz_data_o | bus.div_alu_op_a_o | 32'(bus.div_shift_amt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_valid("rst_mid.no_valid", 40);
        run_op(2'd2, 32'd12345, 32'd100, 1, "after_rst");

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(op, a, b, $urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
